note_scheduler: RTL and testbench
=================================

// Module: note_scheduler
// PURPOSE
//  Sequences the Guitar Hero note chart into the on-screen note window.
//  - On each beat it fetches the next 4-bit chart entry from a synchronous note ROM (loaded from Notes.mem).
//  - It shifts a MAX_NOTES_ON_SCREEN-deep window toward the strike zone.
//  - It judges PS2 strums against the strike-zone slot.
//  - It exports the flattened window to the VGA note renderer, plus hit/miss events and counts.
// PARAMETERS
//  MAX_NOTES_ON_SCREEN  21  window depth; slot 0 = strike zone, slot N-1 = top of screen
//  LANES                3   lane bits per entry (entry[2:0])
//  ADDR_W               10  note ROM address width
//  CNT_W                16  hit/miss counter width
// PORTS
//  clk          in   1                        system clock
//  reset        in   1                        synchronous, active-high; clears all state
//  start        in   1                        pulse: begin song from ROM address 0 (honoured only in IDLE/DONE)
//  pause        in   1                        level: freeze beats and ignore strums
//  beat_tick    in   1                        1-cycle pulse: advance window one slot
//  strum_valid  in   1                        1-cycle pulse from PS2 decoder
//  strum_lanes  in   LANES                    lanes held at strum
//  rom_en       out  1                        note ROM read enable
//  rom_addr     out  ADDR_W                   note ROM address
//  rom_data     in   4                        ROM entry, valid the cycle after rom_en; [3]=END marker, [2:0]=lane mask
//  notes_flat   out  N*LANES                  window; slot k at [k*LANES +: LANES]
//  hit          out  1                        1-cycle pulse, correct strum
//  miss         out  1                        1-cycle pulse, wrong/empty strum or unhit note leaving slot 0
//  hit_count    out  CNT_W                    saturating
//  miss_count   out  CNT_W                    saturating
//  beat_overrun out  1                        sticky: beat_tick dropped during a fetch
//  busy         out  1                        state != IDLE && state != DONE
//  song_done    out  1                        high in DONE
// BEHAVIOUR
//  - Reset: every output is 0; window all zero; ROM pointer 0; state IDLE. Reset mid-song aborts immediately.
//  - FSM states and transitions:
//    - IDLE -start-> PLAY (pointer=0, counters and overrun cleared).
//    - PLAY -beat_tick && !pause-> REQ.
//    - REQ (rom_en=1, rom_addr=ptr) -> WAIT.
//    - WAIT: capture rom_data, shift, ptr++ -> PLAY.
//    - If the captured entry has [3]=1, a zero lane mask is shifted in and the state goes to DRAIN.
//    - If ptr == 2^ADDR_W-1 and [3]=0, the entry is shifted in and the state goes to DRAIN (no address wrap).
//    - DRAIN -beat_tick && !pause-> shift in zero; window all zero after the shift -> DONE.
//    - DONE -start-> PLAY.
//  - Latency: beat_tick sampled at edge T gives rom_en high in cycle T+1. The window shift lands at edge T+2.
//    notes_flat reflects the new window from cycle T+2.
//  - Shift: slot k <= slot k+1; slot N-1 <= new lanes.
//    If slot 0 is nonzero at the shift, miss pulses and miss_count++.
//  - beat_tick in REQ/WAIT is dropped and sets beat_overrun. beat_tick in IDLE/DONE is ignored.
//  - Strums are judged only in PLAY/REQ/WAIT/DRAIN with pause=0; otherwise ignored.
//    - Hit: slot0 != 0 && strum_lanes == slot0. Next cycle hit=1, hit_count++, slot0 cleared.
//    - Otherwise miss=1, miss_count++.
//  - Strum and shift on the same edge:
//    - The strum is judged against the pre-shift slot 0.
//    - On a hit, the departing note is not also counted as a miss.
//    - On a strum miss plus an unhit departing note, miss pulses once and miss_count += 2.
//  - Counters saturate at 2^CNT_W-1. hit and miss are never both high.
//  - pause in REQ/WAIT lets the fetch complete.
// STRUCTURE
//  - note_pkg: entry field constants (END_BIT=3, LANE_MSB=2) and state encoding localparams.
//  - One sub-module, note_window: N x LANES shift register with shift_en, shift_in, clear_slot0, flat output, all_zero flag.
//  - The FSM, judging logic and counters stay in note_scheduler.
// TESTING
//  1. ROM = {3'b001,3'b010,4'b1000}, 3 beats spaced 10 cycles -> rom_addr 0,1,2.
//     slot N-1 = 001 after beat 1; slot N-2 = 001, N-1 = 010 after beat 2; state DRAIN after beat 3.
//  2. Let 001 reach slot 0, strum 001 -> hit=1 one cycle later, hit_count=1, slot0=000.
//     Strum 001 again -> miss, miss_count=1.
//  3. Unhit 100 in slot 0, beat_tick -> miss pulse, miss_count=1.
//     Same case with a matching strum on the same edge -> hit only, miss_count unchanged.
//  4. beat_tick on two consecutive cycles -> second dropped, beat_overrun=1, exactly one rom_en pulse.
//  5. ROM all 3'b111 with ADDR_W=2 -> 4 fetches, DRAIN, N further beats, then song_done=1, busy=0.
//  6. reset asserted in WAIT -> next cycle all outputs 0, notes_flat=0, state IDLE.
//     pause=1 holds the window through 5 beat_ticks.

Source files
------------

// File: rtl/note_pkg.sv
// Shared constants for the note chart scheduler: ROM entry fields and FSM state encoding.
package note_pkg;

   localparam int END_BIT  = 3;
   localparam int LANE_MSB = 2;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PLAY  = 3'd1;
   localparam logic [2:0] ST_REQ   = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_PLAY  = ST_PLAY,
      S_REQ   = ST_REQ,
      S_WAIT  = ST_WAIT,
      S_DRAIN = ST_DRAIN,
      S_DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/note_window.sv
// On-screen note window: slot 0 is the strike zone, new notes enter at slot N-1.
module note_window #(
   parameter int N     = 21,
   parameter int LANES = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift_en,
   input  logic [LANES-1:0]   shift_in,
   input  logic               clear_slot0,
   output logic [N*LANES-1:0] flat,
   output logic               all_zero
);

   logic [N-1:0][LANES-1:0] slot;

   always_ff @(posedge clk) begin
      if (reset) begin
         slot <= '0;
      end else if (shift_en) begin
         slot <= {shift_in, slot[N-1:1]};
      end else if (clear_slot0) begin
         slot[0] <= '0;
      end
   end

   assign flat = slot;
   // Looks past slot 0: true when shifting in an empty entry leaves the window empty.
   assign all_zero = (slot[N-1:1] == '0);

endmodule

// File: rtl/note_scheduler.sv
// Fetches chart entries on each beat, scrolls the note window and judges strums against slot 0.
//
// state | meaning
// IDLE  | no song loaded, waiting for start
// PLAY  | song running, waiting for the next beat
// REQ   | ROM read issued at the current pointer
// WAIT  | ROM data arriving; shift it into the window
// DRAIN | chart exhausted, scrolling remaining notes off screen
// DONE  | window empty, song finished
module note_scheduler
   import note_pkg::*;
#(
   parameter int MAX_NOTES_ON_SCREEN = 21,
   parameter int LANES               = 3,
   parameter int ADDR_W              = 10,
   parameter int CNT_W               = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 pause,
   input  logic                                 beat_tick,
   input  logic                                 strum_valid,
   input  logic [LANES-1:0]                     strum_lanes,
   output logic                                 rom_en,
   output logic [ADDR_W-1:0]                    rom_addr,
   input  logic [3:0]                           rom_data,
   output logic [MAX_NOTES_ON_SCREEN*LANES-1:0] notes_flat,
   output logic                                 hit,
   output logic                                 miss,
   output logic [CNT_W-1:0]                     hit_count,
   output logic [CNT_W-1:0]                     miss_count,
   output logic                                 beat_overrun,
   output logic                                 busy,
   output logic                                 song_done
);

   localparam int CW1 = CNT_W + 1;
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] ptr;
   logic [LANES-1:0]  slot0;
   logic [LANES-1:0]  shift_in;
   logic              shift_en, judge, advance, start_go, win_zero;
   logic              is_hit, strum_miss, depart_miss;
   logic [1:0]        miss_inc;
   logic [CW1-1:0]    hit_sum, miss_sum;

   note_window #(.N(MAX_NOTES_ON_SCREEN), .LANES(LANES)) u_window (
      .clk         (clk),
      .reset       (reset),
      .shift_en    (shift_en),
      .shift_in    (shift_in),
      .clear_slot0 (is_hit),
      .flat        (notes_flat),
      .all_zero    (win_zero)
   );

   assign slot0    = notes_flat[LANES-1:0];
   assign advance  = beat_tick && !pause;
   assign start_go = start && (state == S_IDLE || state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      shift_en = 1'b0;
      shift_in = '0;
      judge    = 1'b0;
      rom_en   = 1'b0;
      case (state)
         S_IDLE, S_DONE: if (start) state_nx = S_PLAY;
         S_PLAY: begin
            judge = 1'b1;
            if (advance) state_nx = S_REQ;
         end
         S_REQ: begin
            judge    = 1'b1;
            rom_en   = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            judge    = 1'b1;
            shift_en = 1'b1;
            shift_in = rom_data[END_BIT] ? '0 : LANES'(rom_data[LANE_MSB:0]);
            // No address wrap: the last ROM word ends the chart even without an END marker.
            state_nx = (rom_data[END_BIT] || ptr == PTR_LAST) ? S_DRAIN : S_PLAY;
         end
         S_DRAIN: begin
            judge = 1'b1;
            if (advance) begin
               shift_en = 1'b1;
               if (win_zero) state_nx = S_DONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // A strum is judged against slot 0 as it stands before any same-edge shift.
   assign is_hit      = judge && strum_valid && !pause && slot0 != '0 && strum_lanes == slot0;
   assign strum_miss  = judge && strum_valid && !pause && !is_hit;
   assign depart_miss = shift_en && slot0 != '0 && !is_hit;
   assign miss_inc    = {1'b0, strum_miss} + {1'b0, depart_miss};
   assign hit_sum     = {1'b0, hit_count} + CW1'(is_hit);
   assign miss_sum    = {1'b0, miss_count} + CW1'(miss_inc);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr          <= '0;
         hit          <= 1'b0;
         miss         <= 1'b0;
         hit_count    <= '0;
         miss_count   <= '0;
         beat_overrun <= 1'b0;
      end else begin
         hit  <= is_hit;
         miss <= strum_miss || depart_miss;
         if (start_go) begin
            ptr          <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            beat_overrun <= 1'b0;
         end else begin
            hit_count  <= hit_sum[CNT_W]  ? '1 : hit_sum[CNT_W-1:0];
            miss_count <= miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
            if (state == S_WAIT && ptr != PTR_LAST) ptr <= ptr + 1'b1;
            if ((state == S_REQ || state == S_WAIT) && advance) beat_overrun <= 1'b1;
         end
      end
   end

   assign rom_addr  = ptr;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign song_done = (state == S_DONE);

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed table, hand sequences and a random run against a window model.
module tb_note_scheduler;

   localparam int N        = 21;
   localparam int L        = 3;
   localparam int PTR_LAST = 1023;
   localparam int CMAX     = 65535;
   localparam int P_IDLE = 0, P_PLAY = 1, P_REQ = 2, P_WAIT = 3, P_DRAIN = 4, P_DONE = 5;

   logic clk = 1'b0;
   logic rst = 1'b0, start = 1'b0, pause = 1'b0, beat = 1'b0, strum = 1'b0;
   logic [2:0] lanes = 3'd0;
   logic rom_en, hit, miss, ovr, busy, done;
   logic [9:0] rom_addr;
   logic [3:0] rom_data = 4'd0;
   logic [N*L-1:0] flat;
   logic [15:0] hc, mc;

   logic start2 = 1'b0, beat2 = 1'b0, pause2 = 1'b0, strum2 = 1'b0;
   logic [2:0] lanes2 = 3'd0;
   logic rom_en2, hit2, miss2, ovr2, busy2, done2;
   logic [1:0] rom_addr2, hc2, mc2;
   logic [3:0] rom_data2 = 4'd0;
   logic [N*L-1:0] flat2;

   logic [3:0] rom_mem [1024];
   logic [3:0] rom2 [4];
   int checks = 0, failures = 0, en_cnt = 0, en2_cnt = 0;

   // reference model state
   int mph = P_IDLE, mptr = 0, mhc = 0, mmc = 0;
   bit movr = 0, mhit = 0, mmiss = 0;
   int mw [N];

   always #5 clk = ~clk;

   note_scheduler dut (
      .clk(clk), .reset(rst), .start(start), .pause(pause), .beat_tick(beat),
      .strum_valid(strum), .strum_lanes(lanes), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .notes_flat(flat), .hit(hit), .miss(miss), .hit_count(hc),
      .miss_count(mc), .beat_overrun(ovr), .busy(busy), .song_done(done));

   note_scheduler #(.ADDR_W(2), .CNT_W(2)) dut2 (
      .clk(clk), .reset(rst), .start(start2), .pause(pause2), .beat_tick(beat2),
      .strum_valid(strum2), .strum_lanes(lanes2), .rom_en(rom_en2), .rom_addr(rom_addr2),
      .rom_data(rom_data2), .notes_flat(flat2), .hit(hit2), .miss(miss2), .hit_count(hc2),
      .miss_count(mc2), .beat_overrun(ovr2), .busy(busy2), .song_done(done2));

   always @(posedge clk) begin
      if (rom_en)  begin rom_data  <= rom_mem[rom_addr];  en_cnt  <= en_cnt + 1;  end
      if (rom_en2) begin rom_data2 <= rom2[rom_addr2];    en2_cnt <= en2_cnt + 1; end
   end

   typedef struct {
      int gap; bit s; bit b;
      bit e_en; bit [9:0] e_addr; bit [2:0] e_top; bit [2:0] e_top1; bit e_busy;
   } vec_t;

   vec_t vt [11] = '{
      '{0, 1, 0, 0, 0, 0, 0, 1},
      '{2, 0, 1, 1, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 1, 0, 1},
      '{7, 0, 1, 1, 1, 1, 0, 1},
      '{0, 0, 0, 0, 0, 1, 0, 1},
      '{0, 0, 0, 0, 0, 2, 1, 1},
      '{7, 0, 1, 1, 2, 2, 1, 1},
      '{0, 0, 0, 0, 0, 2, 1, 1},
      '{0, 0, 0, 0, 0, 0, 2, 1},
      '{3, 0, 1, 0, 0, 0, 0, 1}
   };

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mph = P_IDLE; mptr = 0; mhc = 0; mmc = 0; movr = 0; mhit = 0; mmiss = 0;
      for (int k = 0; k < N; k++) mw[k] = 0;
   endtask

   // Behavioural rules applied once per clock edge with the inputs present at that edge.
   task automatic model_step(input bit r, input bit s, input bit b, input bit sv,
                             input bit [2:0] sl, input bit p);
      bit judge, h, sm, dm, sh, drain_sh, adv, empty;
      int s0, nv;
      logic [3:0] e;
      if (r) begin model_reset(); return; end
      adv = b && !p;
      judge = sv && !p && (mph == P_PLAY || mph == P_REQ || mph == P_WAIT || mph == P_DRAIN);
      s0 = mw[0];
      h = judge && s0 != 0 && int'(sl) == s0;
      sm = judge && !h;
      sh = 0; drain_sh = 0; nv = 0;
      case (mph)
         P_IDLE, P_DONE: if (s) begin mph = P_PLAY; mptr = 0; mhc = 0; mmc = 0; movr = 0; end
         P_PLAY: if (adv) mph = P_REQ;
         P_REQ: begin if (adv) movr = 1; mph = P_WAIT; end
         P_WAIT: begin
            if (adv) movr = 1;
            e = rom_mem[mptr];
            sh = 1;
            nv = e[3] ? 0 : int'(e[2:0]);
            mph = (e[3] || mptr == PTR_LAST) ? P_DRAIN : P_PLAY;
            if (mptr < PTR_LAST) mptr++;
         end
         P_DRAIN: if (adv) begin sh = 1; drain_sh = 1; end
         default: ;
      endcase
      dm = sh && s0 != 0 && !h;
      if (h) mw[0] = 0;
      if (sh) begin
         for (int k = 0; k < N-1; k++) mw[k] = mw[k+1];
         mw[N-1] = nv;
      end
      empty = 1;
      for (int k = 0; k < N; k++) if (mw[k] != 0) empty = 0;
      if (drain_sh && empty) mph = P_DONE;
      mhit = h;
      mmiss = sm || dm;
      mhc = (mhc + int'(h) > CMAX) ? CMAX : mhc + int'(h);
      mmc = (mmc + int'(sm) + int'(dm) > CMAX) ? CMAX : mmc + int'(sm) + int'(dm);
   endtask

   function automatic logic [110:0] act_vec();
      return {rom_en, rom_en ? rom_addr : 10'd0, flat, hit, miss, hc, mc, ovr, busy, done};
   endfunction

   function automatic logic [110:0] exp_vec();
      logic [N*L-1:0] f = '0;
      for (int k = 0; k < N; k++) f[k*L +: L] = 3'(mw[k]);
      return {mph == P_REQ, (mph == P_REQ) ? 10'(mptr) : 10'd0, f, mhit, mmiss,
              16'(mhc), 16'(mmc), movr, (mph != P_IDLE && mph != P_DONE), mph == P_DONE};
   endfunction

   task automatic step(input bit r, input bit s, input bit b, input bit sv,
                       input bit [2:0] sl, input bit p);
      rst = r; start = s; beat = b; strum = sv; lanes = sl; pause = p;
      @(posedge clk); #1;
      model_step(r, s, b, sv, sl, p);
      chk("cycle_vs_model", 128'(act_vec()), 128'(exp_vec()));
      start = 0; beat = 0; strum = 0; start2 = 0; beat2 = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'd0, 0);
   endtask

   task automatic fetch_beat();
      step(0, 0, 1, 0, 3'd0, 0);
      idle(2);
   endtask

   task automatic step2(input bit s, input bit b);
      start2 = s; beat2 = b;
      step(0, 0, 0, 0, 3'd0, 0);
   endtask

   initial begin
      int en0;
      for (int i = 0; i < 1024; i++) rom_mem[i] = 4'd0;
      for (int i = 0; i < 4; i++) rom2[i] = 4'b0111;
      model_reset();

      step(1, 0, 0, 0, 3'd0, 0);
      step(1, 0, 0, 0, 3'd0, 0);
      chk("reset_state", 128'({rom_en, rom_addr, flat, hit, miss, hc, mc, ovr, busy, done}), 128'(0));

      // song 1: 001, 010, END
      rom_mem[0] = 4'b0001; rom_mem[1] = 4'b0010; rom_mem[2] = 4'b1000;
      step(0, 0, 0, 0, 3'd0, 0);
      for (int i = 0; i < 11; i++) begin
         idle(vt[i].gap);
         step(0, vt[i].s, vt[i].b, 0, 3'd0, 0);
         chk($sformatf("table_%0d", i),
             128'({rom_en, rom_en ? rom_addr : 10'd0, flat[N*L-1 -: 3], flat[N*L-4 -: 3], busy}),
             128'({vt[i].e_en, vt[i].e_addr, vt[i].e_top, vt[i].e_top1, vt[i].e_busy}));
      end

      for (int i = 0; i < N-4; i++) step(0, 0, 1, 0, 3'd0, 0);
      chk("song1_slot0_slot1", 128'(flat[5:0]), 128'(6'b010_001));
      step(0, 0, 0, 1, 3'b001, 0);
      chk("strum_hit", 128'({hit, miss, hc, flat[2:0]}), 128'({1'b1, 1'b0, 16'd1, 3'b000}));
      step(0, 0, 0, 1, 3'b001, 0);
      chk("strum_empty_miss", 128'({hit, miss, mc}), 128'({1'b0, 1'b1, 16'd1}));
      step(0, 0, 1, 0, 3'd0, 0);
      step(0, 0, 1, 0, 3'd0, 0);
      chk("unhit_departs", 128'({hit, miss, mc, done, busy}), 128'({1'b0, 1'b1, 16'd2, 1'b1, 1'b0}));

      // song 2: 100, 100, END
      rom_mem[0] = 4'b0100; rom_mem[1] = 4'b0100; rom_mem[2] = 4'b1000;
      step(0, 1, 0, 0, 3'd0, 0);
      repeat (3) fetch_beat();
      for (int i = 0; i < N-3; i++) step(0, 0, 1, 0, 3'd0, 0);
      chk("song2_slot0_slot1", 128'(flat[5:0]), 128'(6'b100_100));
      step(0, 0, 1, 1, 3'b100, 0);
      chk("hit_on_shift", 128'({hit, miss, hc, mc}), 128'({1'b1, 1'b0, 16'd1, 16'd0}));
      step(0, 0, 1, 1, 3'b010, 0);
      chk("double_miss", 128'({hit, miss, mc, done}), 128'({1'b0, 1'b1, 16'd2, 1'b1}));

      // dropped beat while a fetch is in flight
      step(0, 1, 0, 0, 3'd0, 0);
      chk("start_clears", 128'({hc, mc, ovr}), 128'(0));
      en0 = en_cnt;
      step(0, 0, 1, 0, 3'd0, 0);
      step(0, 0, 1, 0, 3'd0, 0);
      chk("overrun_set", 128'(ovr), 128'(1));
      idle(4);
      chk("single_fetch", 128'(en_cnt - en0), 128'(1));

      // reset while waiting on the ROM
      step(0, 0, 1, 0, 3'd0, 0);
      step(0, 0, 0, 0, 3'd0, 0);
      step(1, 0, 0, 0, 3'd0, 0);
      chk("reset_in_wait", 128'({rom_en, rom_addr, flat, hit, miss, hc, mc, ovr, busy, done}), 128'(0));
      step(0, 1, 0, 0, 3'd0, 0);
      fetch_beat();
      en0 = en_cnt;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, (i == 2), 3'b100, 1);
         step(0, 0, 0, 0, 3'd0, 1);
      end
      chk("pause_holds_window", 128'(flat), 128'({3'b100, 60'd0}));
      chk("pause_no_fetch", 128'({en_cnt - en0, hc, mc}), 128'(0));

      // last-address stop on the 2-bit-address instance, with 2-bit saturating counters
      step2(1, 0);
      for (int i = 0; i < 4; i++) begin
         step2(0, 1);
         step2(0, 0); step2(0, 0); step2(0, 0);
      end
      chk("addr_end_fetches", 128'({en2_cnt, busy2, done2}), 128'({32'd4, 1'b1, 1'b0}));
      chk("addr_end_window", 128'(flat2[N*L-1 -: 12]), 128'(12'hFFF));
      for (int i = 0; i < N-1; i++) step2(0, 1);
      chk("drain_before_last", 128'({busy2, done2, flat2[2:0], mc2}), 128'({1'b1, 1'b0, 3'b111, 2'd3}));
      step2(0, 1);
      chk("drain_done", 128'({busy2, done2, flat2, mc2, en2_cnt}),
          128'({1'b0, 1'b1, 63'd0, 2'd3, 32'd4}));

      // random run against the model
      for (int i = 0; i < 1024; i++)
         rom_mem[i] = ($urandom_range(0, 19) == 0) ? 4'b1000 : {1'b0, 3'($urandom_range(0, 7))};
      step(1, 0, 0, 0, 3'd0, 0);
      for (int i = 0; i < 3000; i++) begin
         bit [2:0] sl;
         sl = ($urandom_range(0, 1) == 1) ? 3'(mw[0]) : 3'($urandom_range(0, 7));
         step(($urandom_range(0, 799) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), sl,
              ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
